// File: rtl/voice_env_seq_pkg.sv
// Shared constants and width helper for the voice x envelope index sequencer.
package voice_env_seq_pkg;

  localparam int VOICES_DEF  = 8;
  localparam int V_ENVS_DEF  = 8;
  localparam int FRAME_CNT_W = 16;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/voice_env_seq_idx_delay_line.sv
// Fixed-depth shift register carrying {index, valid}; depth 0 is a plain wire.
module idx_delay_line
  import voice_env_seq_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] idx,
  input  logic         valid,
  output logic [W-1:0] idx_d,
  output logic         valid_d
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign idx_d   = idx;
      assign valid_d = valid;
    end else begin : g_pipe
      logic [W:0] stage [DEPTH];

      // Shifts every cycle regardless of valid so hold bubbles travel downstream.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= {idx, valid};
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign {idx_d, valid_d} = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/voice_env_seq.sv
// Split {voice, env} index sequencer with run/hold, resync and a pipeline-aligned copy.
// Define VOICE_ENV_SEQ_FRAME_CNT_EN to add the 16-bit o_frame_cnt output.
module voice_env_seq
  import voice_env_seq_pkg::*;
#(
  parameter int VOICES     = VOICES_DEF,
  parameter int V_ENVS     = V_ENVS_DEF,
  parameter int V_WIDTH    = idx_width(VOICES),
  parameter int E_WIDTH    = idx_width(V_ENVS),
  parameter int PIPE_DELAY = 2
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       iRST_N,
  input  logic                       i_run,
  input  logic                       i_sync,
  input  logic [V_WIDTH:0]           i_active_voices,
  output logic [V_WIDTH-1:0]         o_voice,
  output logic [E_WIDTH-1:0]         o_env,
  output logic [V_WIDTH+E_WIDTH-1:0] o_xxxx,
  output logic                       o_frame_start,
  output logic                       o_frame_end,
  output logic                       o_voice_last_env,
  output logic [V_WIDTH+E_WIDTH-1:0] o_xxxx_d,
  output logic                       o_valid_d
`ifdef VOICE_ENV_SEQ_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0]     o_frame_cnt
`endif
);

  localparam int IW = V_WIDTH + E_WIDTH;
  localparam logic [V_WIDTH:0]   LIM_MAX  = (V_WIDTH+1)'(VOICES);
  localparam logic [E_WIDTH-1:0] ENV_LAST = E_WIDTH'(V_ENVS - 1);

  logic [V_WIDTH-1:0] voice_q;
  logic [E_WIDTH-1:0] env_q;
  logic [V_WIDTH:0]   lim_q;
  logic [V_WIDTH:0]   lim_in;
  logic               env_last;
  logic               voice_last;
  logic               idx_last;
  logic               idx_first;

  always_comb begin
    lim_in = i_active_voices;
    if (i_active_voices == '0)
      lim_in = (V_WIDTH+1)'(1);
    else if (i_active_voices > LIM_MAX)
      lim_in = LIM_MAX;
  end

  // lim_q only changes while voice_q is 0, so voice_q never sits above lim_q-1.
  assign env_last   = (env_q == ENV_LAST);
  assign voice_last = ({1'b0, voice_q} == (lim_q - (V_WIDTH+1)'(1)));
  assign idx_last   = env_last & voice_last;
  assign idx_first  = (voice_q == '0) && (env_q == '0);

  always_ff @(posedge sCLK_XVXENVS) begin
    if (!iRST_N) begin
      voice_q <= '0;
      env_q   <= '0;
      lim_q   <= LIM_MAX;
    end else if (i_sync) begin
      voice_q <= '0;
      env_q   <= '0;
      lim_q   <= lim_in;
    end else if (i_run) begin
      if (env_last) begin
        env_q <= '0;
        if (voice_last) begin
          voice_q <= '0;
          lim_q   <= lim_in;
        end else begin
          voice_q <= voice_q + V_WIDTH'(1);
        end
      end else begin
        env_q <= env_q + E_WIDTH'(1);
      end
    end
  end

  assign o_voice          = voice_q;
  assign o_env            = env_q;
  assign o_xxxx           = {voice_q, env_q};
  assign o_frame_start    = i_run & idx_first;
  assign o_frame_end      = i_run & idx_last;
  assign o_voice_last_env = i_run & env_last;

`ifdef VOICE_ENV_SEQ_FRAME_CNT_EN
  always_ff @(posedge sCLK_XVXENVS) begin
    if (!iRST_N)
      o_frame_cnt <= '0;
    else if (o_frame_end)
      o_frame_cnt <= o_frame_cnt + FRAME_CNT_W'(1);
  end
`endif

  idx_delay_line #(
    .W     (IW),
    .DEPTH (PIPE_DELAY)
  ) u_delay (
    .clk     (sCLK_XVXENVS),
    .rst_n   (iRST_N),
    .idx     (o_xxxx),
    .valid   (i_run),
    .idx_d   (o_xxxx_d),
    .valid_d (o_valid_d)
  );

endmodule
